// File: rtl/stl_skid_buf_pkg.sv
// rtl/stl_skid_buf_pkg.sv - shared pipeline types for the skid buffer
package stl_skid_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/stl_skid_ctrl.sv
// rtl/stl_skid_ctrl.sv - occupancy state machine and write enables for the skid buffer
module stl_skid_ctrl
    import stl_skid_buf_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic       i_ready,
    input  logic       i_flush,
    output logic       o_valid,
    output logic       o_ready,
    output logic [1:0] o_cnt,
    output logic       main_wen,
    output logic       skid_wen,
    output logic       main_sel_skid
);

    skid_state_t state;
    skid_state_t state_nxt;
    logic        in_fire;
    logic        out_fire;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        o_valid       = (state != EMPTY);
        o_ready       = (state != FULL);
        o_cnt         = state;
        in_fire       = i_valid & o_ready;
        out_fire      = o_valid & i_ready;
        state_nxt     = state;
        main_wen      = 1'b0;
        skid_wen      = 1'b0;
        main_sel_skid = 1'b0;
        // Flush drops any beat that fires alongside it, so no register loads.
        if (i_flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        main_wen  = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_wen = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = FULL;
                        skid_wen  = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt     = ONE;
                        main_wen      = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/stl_skid_buf.sv
// rtl/stl_skid_buf.sv - two-entry registered valid/ready skid buffer with flush
module stl_skid_buf
    import stl_skid_buf_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_dout,
    input  logic             i_flush,
    output logic [1:0]       o_cnt
);

    logic             main_wen;
    logic             skid_wen;
    logic             main_sel_skid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    stl_skid_ctrl u_ctrl (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .o_cnt         (o_cnt),
        .main_wen      (main_wen),
        .skid_wen      (skid_wen),
        .main_sel_skid (main_sel_skid)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            main_q <= RESET_VAL;
            skid_q <= RESET_VAL;
        end else begin
            if (main_wen) begin
                main_q <= main_sel_skid ? skid_q : i_din;
            end
            if (skid_wen) begin
                skid_q <= i_din;
            end
        end
    end

    assign o_dout = main_q;

endmodule
